// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core.
// The fetch stage uses the address/data widths, the reset PC and the PC increment.
package mips_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO.
// Supports push and pop in the same cycle (even when full) and a single-cycle flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  // NOTE: the storage is only a few flops, so it is cleared on reset.
  // This makes the head word read as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: the PC, one fetch per cycle from the instruction memory, and a buffer to decode.
// Optional FETCH_ALIGN_CHECK_EN turns a misaligned redirect into a sticky fault that halts fetch.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = mips_pkg::ADDR_W,
  parameter int                DATA_W    = mips_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  redirect_target;
  logic               fetch_en;
  logic               pop;
  logic               halt;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign redirect_target = redirect_pc;

  // Sticky until reset; a misaligned target is still loaded so it can be inspected.
  always_ff @(posedge clk) begin
    if (rst)                                        fault_q <= 1'b0;
    else if (redirect_valid && |redirect_pc[1:0]) fault_q <= 1'b1;
  end

  assign halt  = fault_q;
  assign fault = fault_q;
`else
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign halt            = 1'b0;
  assign fault           = 1'b0;
`endif

  // A pop frees a slot this cycle, so a full buffer can still take a new fetch.
  assign pop       = !empty && out_ready;
  assign out_valid = (count != '0);
  assign fetch_en  = !redirect_valid && !halt && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_target;
    else if (fetch_en)       pc <= pc + ADDR_W'(PC_INC);
  end

  assign imem_addr = pc;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch_en),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, imem_instr}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_pc    = head[ENTRY_W-1 -: ADDR_W];
  assign out_instr = head[DATA_W-1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus random traffic.
// A queue-based model is compared against the DUT every cycle.
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  localparam int DEPTH = 2;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] salt = '0;

  always #5 clk = ~clk;

  // The memory returns a word derived from its address.
  // With salt = 0 this gives word[i] = i*4.
  assign imem_instr = imem_addr ^ salt;

  instruction_fetch_unit #(.BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: a queue of buffered entries, the next fetch address and the fault flag.
  fetch_entry_t mq[$];
  logic [31:0]  m_pc    = RESET_PC;
  logic         m_fault = 1'b0;
  bit           chk_en  = 1'b0;

  always @(posedge clk) begin
    fetch_entry_t e;
    bit           do_pop;
    bit           do_fetch;
    if (rst) begin
      mq.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else begin
      do_pop   = (mq.size() != 0) && out_ready;
      do_fetch = !redirect_valid && !m_fault && ((mq.size() < DEPTH) || do_pop);
      if (do_pop) void'(mq.pop_front());
      if (redirect_valid) begin
        mq.delete();
        if (ALIGN_CHK) begin
          if (redirect_pc % 4 != 0) m_fault = 1'b1;
          m_pc = redirect_pc;
        end else begin
          m_pc = redirect_pc - (redirect_pc % 4);
        end
      end else if (do_fetch) begin
        e.pc    = m_pc;
        e.instr = m_pc ^ salt;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("out_pc", out_pc, mq[0].pc);
        check("out_instr", out_instr, mq[0].instr);
      end
      check("imem_addr", imem_addr, m_pc);
      check("fault", fault, m_fault);
    end
  end

  // Log of words actually handed to decode, used to pin the directed scenarios.
  logic [31:0] dlog[$];
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) dlog.push_back(out_pc);
  end

  task automatic check_log(input string name, input int n,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] ex[4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    check({name, " count"}, 64'(dlog.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check(name, (i < dlog.size()) ? 64'(dlog[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(ex[i]));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1 chk_en = 1'b1;
    step(1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_pc", out_pc, 32'h0);
    check("reset out_instr", out_instr, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    check("reset fault", fault, 1'b0);

    // Streaming after reset release.
    rst = 1'b0;
    dlog.delete();
    check("first cycle valid", out_valid, 1'b0);
    step(1);
    check("first word valid", out_valid, 1'b1);
    check("first word pc", out_pc, 32'h0);
    step(4);
    check_log("stream", 4, 32'h0, 32'h4, 32'h8, 32'hC);

    // Backpressure.
    do_reset();
    out_ready = 1'b0;
    step(5);
    check("bp imem_addr", imem_addr, 32'h8);
    check("bp out_pc", out_pc, 32'h0);
    check("bp out_valid", out_valid, 1'b1);
    dlog.delete();
    out_ready = 1'b1;
    step(3);
    check_log("bp release", 3, 32'h0, 32'h4, 32'h8, 32'h0);

    // Redirect while the buffer holds 0x8 and 0xC.
    do_reset();
    step(3);
    out_ready = 1'b0;
    step(1);
    check("pre-redirect head", out_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    check("redirect flush valid", out_valid, 1'b0);
    check("redirect imem_addr", imem_addr, 32'h40);
    dlog.delete();
    out_ready = 1'b1;
    step(1);
    check("redirect target pc", out_pc, 32'h40);
    step(2);
    check_log("redirect", 2, 32'h40, 32'h44, 32'h0, 32'h0);

    // Redirect in the same cycle decode accepts head 0x10.
    do_reset();
    step(5);
    check("head 0x10", out_pc, 32'h10);
    dlog.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    check("redirect+pop valid", out_valid, 1'b0);
    step(2);
    check_log("redirect+pop", 2, 32'h10, 32'h80, 32'h0, 32'h0);

    // PC wrap-around.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step(1);
    redirect_valid = 1'b0;
    dlog.delete();
    step(4);
    check_log("wrap", 3, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h12;
    step(1);
    redirect_valid = 1'b0;
    check("misalign fault", fault, ALIGN_CHK);
    check("misalign valid", out_valid, 1'b0);
    dlog.delete();
    step(3);
    check_log("misalign", ALIGN_CHK ? 0 : 2, 32'h10, 32'h14, 32'h0, 32'h0);
    check("misalign fault held", fault, ALIGN_CHK);
    check("misalign valid after", out_valid, !ALIGN_CHK);
    do_reset();
    check("fault cleared", fault, 1'b0);

    // Random traffic against the model.
    salt = $urandom;
    for (int i = 0; i < 2500; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 15))
        0:       redirect_pc = $urandom;
        1, 2:    redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: redirect_pc = $urandom & 32'hFFFF_FFFC;
      endcase
      step(1);
    end
    rst            = 1'b0;
    redirect_valid = 1'b0;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the MIPS core: the initiator that drives addresses into INSTRUCTION_MEMORY and consumes the returned instruction words. It owns the program counter, fetches one word per cycle from the combinational instruction memory, and buffers fetched words in a small FIFO. The buffer feeds decode over a valid/ready handshake and is flushed on a branch/jump redirect.

## Interface
- ADDR_W, 32, PC and memory address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  ADDR_W  address to INSTRUCTION_MEMORY; equals the current PC (combinational from the PC register)
- imem_instr  in  DATA_W  instruction word from INSTRUCTION_MEMORY, valid in the same cycle as imem_addr
- redirect_valid  in  1  branch/jump taken; flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- out_valid  out  1  buffer head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  DATA_W  head instruction word
- out_pc  out  ADDR_W  address of the head instruction
- fault  out  1  misaligned-redirect fault; sticky (see Configuration)

## Operation
- Registers: pc, FIFO of {pc, instr} entries, count (0..BUF_DEPTH), rd/wr pointers, fault.
- fetch_en = !redirect_valid && !fault && (count < BUF_DEPTH || (out_valid && out_ready)).
- When fetch_en is high: push {pc, imem_instr}; pc <= pc + 4.
- pop = out_valid && out_ready. Push and pop may occur in the same cycle, including when the FIFO is full; count is then unchanged.
- out_valid = (count != 0). out_instr and out_pc come from the head entry, registered.
- Redirect cycle: a pop in this cycle still completes, because decode has consumed the word. All other entries are discarded: count <= 0 and pointers reset. pc <= redirect_pc. No push occurs.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, and fetch continues.
- No states beyond the FIFO status: EMPTY (count 0), PARTIAL, FULL (count = BUF_DEPTH), and a FAULT halt when the macro is enabled.

## Timing
- Reset values: pc = RESET_PC, imem_addr = RESET_PC, count = 0, out_valid = 0, out_instr = 0, out_pc = 0, fault = 0.
- Reset applied mid-stream discards all entries on the next edge.
- Latency: a word fetched at edge N is visible on out_* after edge N (1 cycle).
- First out_valid appears in the cycle after rst deasserts and one edge passes.
- Redirect asserted in cycle N: out_valid = 0 in cycle N+1. imem_addr = redirect_pc in cycle N+1. The target instruction appears on out_* in cycle N+2.
- Throughput: with out_ready held high, one instruction per cycle.
- With out_ready low, the FIFO fills in BUF_DEPTH cycles, then pc holds and imem_addr is stable.
- out_* are stable while out_valid && !out_ready, unless a redirect or reset occurs.

## Configuration
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_pc[1:0] != 2'b00 sets fault on the next edge, flushes the FIFO, and loads pc with redirect_pc unmodified.
  - fault is sticky and fetching halts until rst.
- Undefined:
  - redirect_pc[1:0] is forced to 2'b00 on load.
  - fault is tied to 0 and no halt logic is present.
- RESET_PC must be word-aligned in both cases.

## Structure
- Shared package mips_pkg holds:
  - ADDR_W/DATA_W constants, RESET_PC default, and the PC increment constant 4.
  - typedef fetch_entry_t {pc, instr}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO with push, pop, flush, full, empty, count and simultaneous push/pop support.
- The top level contains the PC logic, the fetch_en logic and the fault logic.

## Test plan
- Reset then out_ready=1, with memory word[i] = i*4: out_pc sequence 0x0, 0x4, 0x8, 0xC, each with the matching instr, first valid one cycle after reset release.
- Backpressure: out_ready=0 for 5 cycles. count saturates at 2, imem_addr holds at 0x8, out_pc holds at 0x0. On release, 0x0, 0x4, 0x8 are delivered in order with no loss or duplication.
- Redirect to 0x40 while the FIFO holds 0x8 and 0xC: next cycle out_valid=0; then out_pc=0x40 and 0x44. No stale 0xC is delivered.
- Redirect together with out_ready=1 on head 0x10: 0x10 counts as delivered; the next delivered out_pc is the redirect target.
- Wrap: redirect to 32'hFFFF_FFF8 gives out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Misaligned redirect to 32'h12:
  - With FETCH_ALIGN_CHECK_EN: fault=1 next cycle, out_valid stays 0, and both persist until rst.
  - Without the macro: fault stays 0 and fetch resumes at out_pc=0x10.
